// File: rtl/datastream_arbiter.sv
// Round-robin burst arbiter feeding N valid/ready sources into one analyzer.
// Optional transfer statistics enabled by DATASTREAM_ARBITER_STATS_EN.
module datastream_arbiter #(
  parameter int DATASIZE = 8,
  parameter int NBSRC    = 4,
  parameter int BURSTLEN = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NBSRC*DATASIZE-1:0] src_data_i,
  input  logic [NBSRC-1:0]          src_valid_i,
  output logic [NBSRC-1:0]          src_ready_o,
  output logic [DATASIZE-1:0]       ana_data_o,
  output logic                      ana_valid_o,
  input  logic                      ana_ready_i,
  output logic [NBSRC-1:0]          grant_o,
`ifdef DATASTREAM_ARBITER_STATS_EN
  output logic [15:0]               xfer_cnt_o,
`endif
  output logic                      busy_o
);

  localparam int IW = $clog2(NBSRC);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [7:0]    cnt_q;
  logic          xfer;
  logic          rel;
  int            k;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant index, burst counter and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q  <= '0;
      cnt_q  <= '0;
      last_q <= IW'(NBSRC - 1);
    end else if (state_q == IDLE) begin
      if (sel_found) begin
        gnt_q <= sel_idx;
        cnt_q <= '0;
      end
    end else begin
      if (xfer) cnt_q <= cnt_q + 8'd1;
      if (rel)  last_q <= gnt_q;
    end
  end

  // Pick first valid source after the last granted one
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    k         = 0;
    for (int i = NBSRC; i >= 1; i--) begin
      k = (int'(last_q) + i) % NBSRC;
      if (src_valid_i[k]) begin
        sel_idx   = k[IW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // Transfer and release detection; source idle beats burst count
  always_comb begin
    xfer = (state_q == GRANT) & ana_valid_o & ana_ready_i;
    rel  = 1'b0;
    if (state_q == GRANT) begin
      rel = !src_valid_i[gnt_q] ||
            (xfer && (cnt_q == 8'(BURSTLEN - 1)));
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (sel_found) state_d = GRANT;
      GRANT: if (rel)       state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output mux: only the granted source sees the analyzer
  always_comb begin
    src_ready_o = '0;
    ana_data_o  = '0;
    ana_valid_o = 1'b0;
    grant_o     = '0;
    busy_o      = (state_q == GRANT);
    if (state_q == GRANT) begin
      grant_o[gnt_q]     = 1'b1;
      ana_data_o         = src_data_i[gnt_q*DATASIZE +: DATASIZE];
      ana_valid_o        = src_valid_i[gnt_q];
      src_ready_o[gnt_q] = ana_ready_i;
    end
  end

`ifdef DATASTREAM_ARBITER_STATS_EN
  logic [15:0] xfer_cnt_q;

  // Free-running transfer count, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i)     xfer_cnt_q <= '0;
    else if (xfer) xfer_cnt_q <= xfer_cnt_q + 16'd1;
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_datastream_arbiter.sv
// Directed bench for datastream_arbiter.
// Sources emit {id, seq}; seq advances only on their own handshake.
module tb_datastream_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS*DW-1:0] sdata;
  logic [NS-1:0]    svalid;
  logic [NS-1:0]    sready;
  logic [DW-1:0]    adata;
  logic             avalid;
  logic             aready;
  logic [NS-1:0]    grant;
  logic             busy;
`ifdef DATASTREAM_ARBITER_STATS_EN
  logic [15:0]      xcnt;
`endif

  int        n_vec = 0;
  int        n_err = 0;
  int        total = 0;
  logic [5:0] seq[NS];
  logic [5:0] exp_seq[NS];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_src
    assign sdata[g*DW +: DW] = {2'(g), seq[g]};
  end

  datastream_arbiter #(
    .DATASIZE(DW),
    .NBSRC(NS),
    .BURSTLEN(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .src_data_i(sdata),
    .src_valid_i(svalid),
    .src_ready_o(sready),
    .ana_data_o(adata),
    .ana_valid_o(avalid),
    .ana_ready_i(aready),
    .grant_o(grant),
`ifdef DATASTREAM_ARBITER_STATS_EN
    .xfer_cnt_o(xcnt),
`endif
    .busy_o(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    logic [NS-1:0] acc;
    acc = svalid & sready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (acc[i] === 1'b1) seq[i] = seq[i] + 6'd1;
    #1;
  endtask

  task automatic burst(input int s, input int n);
    logic [7:0] d;
    for (int j = 0; j < n; j++) begin
      d = {s[1:0], exp_seq[s]};
      chk("grant", {28'd0, grant}, 32'd1 << s);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("data", {24'd0, adata}, {24'd0, d});
      chk("src_ready", {28'd0, sready}, 32'd1 << s);
      exp_seq[s] = exp_seq[s] + 6'd1;
      total++;
      cyc();
    end
  endtask

  task automatic idle();
    chk("idle_grant", {28'd0, grant}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, avalid}, 32'd0);
    chk("idle_ready", {28'd0, sready}, 32'd0);
    chk("idle_data", {24'd0, adata}, 32'd0);
    cyc();
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      seq[i]     = '0;
      exp_seq[i] = '0;
    end
    rst    = 1'b1;
    svalid = 4'b1111;
    aready = 1'b1;
    #1;
    cyc();
    cyc();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, avalid}, 32'd0);
    chk("rst_ready", {28'd0, sready}, 32'd0);
    chk("rst_data", {24'd0, adata}, 32'd0);

    rst    = 1'b0;
    svalid = 4'b0101;
    #1;
    idle();
    burst(0, 4);
    idle();
    burst(2, 4);
    svalid = 4'b0000;
    #1;
    idle();

    svalid = 4'b0010;
    #1;
    idle();
    burst(1, 2);
    svalid = 4'b0000;
    #1;
    chk("srcidle_grant", {28'd0, grant}, 32'd2);
    chk("srcidle_busy", {31'd0, busy}, 32'd1);
    chk("srcidle_valid", {31'd0, avalid}, 32'd0);
    cyc();
    idle();

    svalid = 4'b1000;
    aready = 1'b0;
    #1;
    idle();
    for (int j = 0; j < 5; j++) begin
      chk("stall_grant", {28'd0, grant}, 32'd8);
      chk("stall_valid", {31'd0, avalid}, 32'd1);
      chk("stall_ready", {28'd0, sready}, 32'd0);
      chk("stall_data", {24'd0, adata}, {24'd0, 2'd3, exp_seq[3]});
      cyc();
    end
    aready = 1'b1;
    #1;
    burst(3, 4);
    svalid = 4'b0000;
    #1;
    idle();

    svalid = 4'b1111;
    #1;
    idle();
    for (int s = 0; s < NS; s++) begin
      burst(s, 4);
      idle();
    end
    burst(0, 4);
    idle();
    burst(1, 2);

    rst    = 1'b1;
    aready = 1'b0;
    #1;
    cyc();
    chk("mrst_grant", {28'd0, grant}, 32'd0);
    chk("mrst_valid", {31'd0, avalid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {28'd0, sready}, 32'd0);
`ifdef DATASTREAM_ARBITER_STATS_EN
    chk("mrst_xcnt", {16'd0, xcnt}, 32'd0);
`endif
    total  = 0;
    rst    = 1'b0;
    aready = 1'b1;
    #1;
    idle();
    burst(0, 4);
    idle();
`ifdef DATASTREAM_ARBITER_STATS_EN
    chk("xfer_cnt", {16'd0, xcnt}, total);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
